// File: rtl/result_serializer_if.sv
// Result/byte-stream bundle between the 2x2 multiplier, the serializer and the byte consumer.
// The slave modport is the serializer's view; master is the surrounding system.
interface result_serializer_if #(
   parameter int DATA_W = 16,
   parameter int N_ELEM = 4,
   parameter int OUT_W  = 8
);
   logic [N_ELEM*DATA_W-1:0] result_flat;
   logic                     multiplication_done;
   logic [OUT_W-1:0]         out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_last;
   logic                     busy;
   logic                     overrun;

   modport master (
      output result_flat, multiplication_done, out_ready,
      input  out_data, out_valid, out_last, busy, overrun
   );

   modport slave (
      input  result_flat, multiplication_done, out_ready,
      output out_data, out_valid, out_last, busy, overrun
   );
endinterface

// File: rtl/result_serializer.sv
// Captures a 4x16 result frame on the rising edge of multiplication_done and streams it
// MSB-first as bytes over valid/ready, with one pending frame slot and a sticky overrun flag.
module result_serializer #(
   parameter int DATA_W = 16,
   parameter int N_ELEM = 4,
   parameter int OUT_W  = 8
) (
   input logic                clk,
   input logic                rst,
   result_serializer_if.slave bus
);
   localparam int FRAME_W = N_ELEM * DATA_W;
   localparam int NBYTES  = FRAME_W / OUT_W;
   localparam int IDX_W   = $clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             r_state, w_stateNext;
   logic [FRAME_W-1:0] r_active, w_activeNext;
   logic [FRAME_W-1:0] r_pending, w_pendingNext;
   logic [IDX_W-1:0]   r_index, w_indexNext;
   logic               r_pendValid, w_pendValidNext;
   logic               r_overrun, w_overrunNext;
   logic               r_doneQ;
   logic               w_event;
   logic               w_accept;
   logic               w_final;
   logic [OUT_W-1:0]   w_outData;

   assign w_event  = bus.multiplication_done & ~r_doneQ;
   assign w_accept = (r_state == SEND) & bus.out_ready;
   assign w_final  = w_accept & (r_index == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_active    <= '0;
         r_pending   <= '0;
         r_index     <= '0;
         r_pendValid <= 1'b0;
         r_overrun   <= 1'b0;
         r_doneQ     <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_active    <= w_activeNext;
         r_pending   <= w_pendingNext;
         r_index     <= w_indexNext;
         r_pendValid <= w_pendValidNext;
         r_overrun   <= w_overrunNext;
         r_doneQ     <= bus.multiplication_done;
      end
   end

   // A final-byte accept frees the active slot, so an event in that cycle never overruns.
   always_comb begin
      w_stateNext     = r_state;
      w_activeNext    = r_active;
      w_pendingNext   = r_pending;
      w_indexNext     = r_index;
      w_pendValidNext = r_pendValid;
      w_overrunNext   = r_overrun;
      case (r_state)
         IDLE: begin
            if (w_event) begin
               w_activeNext = bus.result_flat;
               w_indexNext  = '0;
               w_stateNext  = SEND;
            end
         end
         SEND: begin
            if (w_final) begin
               w_indexNext = '0;
               if (r_pendValid) begin
                  w_activeNext    = r_pending;
                  w_pendValidNext = w_event;
                  if (w_event) begin
                     w_pendingNext = bus.result_flat;
                  end
               end else if (w_event) begin
                  w_activeNext = bus.result_flat;
               end else begin
                  w_stateNext = IDLE;
               end
            end else begin
               if (w_accept) begin
                  w_indexNext = r_index + 1'b1;
               end
               if (w_event) begin
                  if (!r_pendValid) begin
                     w_pendingNext   = bus.result_flat;
                     w_pendValidNext = 1'b1;
                  end else begin
                     w_overrunNext = 1'b1;
                  end
               end
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Byte 0 is the most significant byte of the frame (C11 high byte).
   always_comb begin
      w_outData = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if ((r_state == SEND) && (r_index == IDX_W'(i))) begin
            w_outData = r_active[(NBYTES-1-i)*OUT_W +: OUT_W];
         end
      end
   end

   assign bus.out_data  = w_outData;
   assign bus.out_valid = (r_state == SEND);
   assign bus.out_last  = (r_state == SEND) && (r_index == LAST_IDX);
   assign bus.busy      = (r_state == SEND) | r_pendValid;
   assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: a fixed vector table, directed multi-cycle
// sequences and randomized traffic, all compared against a frame-queue reference model.
module tb_result_serializer;
   localparam logic [63:0] FRAME1 = 64'h000B_0019_002C_0064;
   localparam logic [63:0] FRAME2 = 64'h0102_0304_0506_0708;
   localparam logic [63:0] FRAME3 = 64'hDEAD_BEEF_CAFE_F00D;

   typedef struct {
      logic        rst;
      logic        done;
      logic        ready;
      logic [63:0] flat;
      logic        expValid;
      logic [7:0]  expData;
      logic        expLast;
      logic        expBusy;
      logic        expOverrun;
   } vecT;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int checks = 0;
   int errors = 0;

   // Reference model: frames waiting to go out (front is the one being sent).
   logic [63:0] modelQ[$];
   int          modelPos = 0;
   logic        modelOvr = 1'b0;
   logic        modelPrevDone = 1'b0;
   logic [7:0]  seen[$];

   result_serializer_if bus ();

   result_serializer dut (
      .clk (clock),
      .rst (reset),
      .bus (bus)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [7:0] modelByte();
      logic [63:0] f;
      if (modelQ.size() == 0) return 8'h00;
      f = modelQ[0] >> ((7 - modelPos) * 8);
      return f[7:0];
   endfunction

   task automatic modelStep(input logic rst, input logic done, input logic ready, input logic [63:0] flat);
      logic ev;
      if (rst) begin
         modelQ.delete();
         modelPos      = 0;
         modelOvr      = 1'b0;
         modelPrevDone = 1'b0;
         return;
      end
      ev = done && !modelPrevDone;
      modelPrevDone = done;
      if (modelQ.size() != 0 && ready) begin
         modelPos++;
         if (modelPos == 8) begin
            void'(modelQ.pop_front());
            modelPos = 0;
         end
      end
      if (ev) begin
         if (modelQ.size() < 2) modelQ.push_back(flat);
         else modelOvr = 1'b1;
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check outputs against the model,
   // record the byte if it will be accepted, then advance the model to match the next edge.
   task automatic applyStimulus(input logic rst, input logic done, input logic ready, input logic [63:0] flat);
      @(negedge clock);
      reset                   = rst;
      bus.multiplication_done = done;
      bus.out_ready           = ready;
      bus.result_flat         = flat;
      #1;
      checkOutput("out_valid", 64'(bus.out_valid), 64'(modelQ.size() != 0));
      checkOutput("out_data", 64'(bus.out_data), 64'(modelByte()));
      checkOutput("out_last", 64'(bus.out_last), 64'((modelQ.size() != 0) && (modelPos == 7)));
      checkOutput("busy", 64'(bus.busy), 64'(modelQ.size() != 0));
      checkOutput("overrun", 64'(bus.overrun), 64'(modelOvr));
      if (bus.out_valid && ready && !rst) seen.push_back(bus.out_data);
      modelStep(rst, done, ready, flat);
   endtask

   task automatic checkSeen(input string name, input logic [63:0] f0, input logic [63:0] f1, input int nFrames);
      logic [63:0] f;
      checkOutput({name, "_count"}, 64'(seen.size()), 64'(nFrames * 8));
      for (int i = 0; i < nFrames * 8 && i < seen.size(); i++) begin
         f = (i < 8 ? f0 : f1) >> ((7 - (i % 8)) * 8);
         checkOutput({name, "_byte"}, 64'(seen[i]), 64'(f[7:0]));
      end
      seen.delete();
   endtask

   initial begin
      vecT vecs[10];
      int  validCycles;

      bus.multiplication_done = 1'b0;
      bus.out_ready           = 1'b0;
      bus.result_flat         = '0;

      vecs[0] = '{1'b0, 1'b1, 1'b1, FRAME1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 64'h0,  1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 64'h0,  1'b1, 8'h0B, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 64'h0,  1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 64'h0,  1'b1, 8'h19, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 64'h0,  1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 64'h0,  1'b1, 8'h2C, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 1'b1, 64'h0,  1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 1'b0, 1'b1, 64'h0,  1'b1, 8'h64, 1'b1, 1'b1, 1'b0};
      vecs[9] = '{1'b0, 1'b0, 1'b1, 64'h0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

      $display("[TB] reset and basic frame table");
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].done, vecs[i].ready, vecs[i].flat);
         checkOutput("tbl_valid", 64'(bus.out_valid), 64'(vecs[i].expValid));
         checkOutput("tbl_data", 64'(bus.out_data), 64'(vecs[i].expData));
         checkOutput("tbl_last", 64'(bus.out_last), 64'(vecs[i].expLast));
         checkOutput("tbl_busy", 64'(bus.busy), 64'(vecs[i].expBusy));
         checkOutput("tbl_overrun", 64'(bus.overrun), 64'(vecs[i].expOverrun));
      end

      $display("[TB] backpressure");
      seen.delete();
      applyStimulus(1'b0, 1'b1, 1'b1, FRAME1);
      for (int c = 0; c < 40 && seen.size() < 8; c++) begin
         applyStimulus(1'b0, 1'b0, (c % 3) == 0, 64'h0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h0);
      checkSeen("backpressure", FRAME1, 64'h0, 1);

      $display("[TB] level done");
      for (int c = 0; c < 20; c++) applyStimulus(1'b0, 1'b1, 1'b1, FRAME2);
      for (int c = 0; c < 15; c++) applyStimulus(1'b0, 1'b0, 1'b1, 64'h0);
      checkSeen("level_done", FRAME2, 64'h0, 1);

      $display("[TB] pending without bubble");
      validCycles = 0;
      applyStimulus(1'b0, 1'b1, 1'b1, FRAME1);
      for (int c = 0; c < 16; c++) begin
         applyStimulus(1'b0, c == 3, 1'b1, (c == 3) ? FRAME2 : 64'h0);
         if (bus.out_valid) validCycles++;
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h0);
      checkOutput("pend_continuous", 64'(validCycles), 64'd16);
      checkOutput("pend_idle_after", 64'(bus.out_valid), 64'd0);
      checkOutput("pend_no_overrun", 64'(bus.overrun), 64'd0);
      checkSeen("pending", FRAME1, FRAME2, 2);

      $display("[TB] overrun");
      applyStimulus(1'b0, 1'b1, 1'b0, FRAME1);
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, FRAME2);
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, FRAME3);
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("ovr_set", 64'(bus.overrun), 64'd1);
      for (int c = 0; c < 30; c++) applyStimulus(1'b0, 1'b0, 1'b1, 64'h0);
      checkOutput("ovr_sticky", 64'(bus.overrun), 64'd1);
      checkSeen("overrun", FRAME1, FRAME2, 2);

      $display("[TB] reset mid-frame");
      applyStimulus(1'b0, 1'b1, 1'b1, FRAME3);
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b1, 64'h0);
      applyStimulus(1'b1, 1'b0, 1'b1, 64'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h0);
      checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("rst_overrun", 64'(bus.overrun), 64'd0);
      seen.delete();
      applyStimulus(1'b0, 1'b1, 1'b1, FRAME1);
      for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b0, 1'b1, 64'h0);
      checkSeen("after_reset", FRAME1, 64'h0, 1);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 3000; c++) begin
         applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) != 0, {$urandom, $urandom});
      end
      seen.delete();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/result_serializer.md
# result_serializer

Downstream stage of the 2x2 matrix multiplier. It captures the four 16-bit result elements when the multiplier signals completion. It then streams them out as eight bytes over a valid/ready byte interface, one byte per accepted cycle. A one-frame pending buffer lets the multiplier finish a new product while the previous frame is still draining; a sticky flag reports any frame that had to be dropped.

## Interface

- DATA_W, 16, width of one result element
- N_ELEM, 4, result elements per frame (C11, C12, C21, C22)
- OUT_W, 8, output byte width; DATA_W must be a multiple of OUT_W

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- result_flat  in  N_ELEM*DATA_W  packed results: C11 in [63:48], C12 [47:32], C21 [31:16], C22 [15:0]
- multiplication_done  in  1  completion from multiplier; level or pulse, rising edge is the event
- out_data  out  OUT_W  current byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts byte when out_valid && out_ready
- out_last  out  1  high with the final byte (index 7) of a frame
- busy  out  1  a frame is active or pending
- overrun  out  1  sticky; a frame was dropped; cleared only by rst

## Operation

- Edge detect: event = multiplication_done & ~done_q; done_q is a register, reset 0. A done held high across reset therefore counts as one event in the first cycle after reset.
- On event, result_flat is sampled in that same cycle.
- Storage:
  - active frame register (4x16) plus byte index 0..7
  - pending register (4x16) plus pending_valid
- States:
  - IDLE: out_valid=0.
    - event -> load active, index=0, go SEND.
  - SEND: out_valid=1. out_data is byte [index] of the active frame.
    - Byte order is element order C11, C12, C21, C22, high byte first: index 2k = elem k [15:8], index 2k+1 = elem k [7:0].
    - On accept with index<7: index++.
    - On accept with index==7 (final byte):
      - pending_valid -> move pending into active, index=0, pending_valid=0, stay SEND.
      - else if event this cycle -> load result_flat into active, index=0, stay SEND.
      - else go IDLE.
- Event while in SEND (not consumed by the final-byte rule above):
  - pending empty -> store into pending, pending_valid=1.
  - pending full, final byte accepted this cycle -> pending moves to active and the new frame goes into pending; no overrun.
  - pending full, no final accept -> frame dropped, overrun=1.
- Backpressure: while out_valid && !out_ready, out_data, out_last and index hold stable.
- out_last = (state==SEND && index==7).
- busy = (state==SEND) | pending_valid.
- Reset mid-frame: active and pending are discarded and the state machine returns to IDLE; no partial frame resumes.

## Timing

- Reset values: out_valid 0, out_data 0, out_last 0, busy 0, overrun 0, pending_valid 0, index 0, done_q 0, state IDLE.
- Latency: event sampled at edge N; out_valid=1 with byte 0 from edge N+1.
- Throughput: 1 byte/cycle with out_ready held high, so a frame takes 8 cycles.
- Back-to-back frames (pending, or event on the final accept) produce no bubble: out_valid stays high and byte 0 of the next frame follows byte 7 on the next cycle.
- overrun rises the cycle after the dropping event and stays high until rst.
- All outputs are registered or decoded from registers; there is no combinational path from out_ready or result_flat to outputs.

## Test plan

- Basic frame: results C11=0x000B, C12=0x0019, C21=0x002C, C22=0x0064, one-cycle done pulse, out_ready=1.
  -> bytes 00 0B 00 19 00 2C 00 64 on 8 consecutive cycles starting 1 cycle after the event; out_last only on 0x64; then busy=0.
- Backpressure: same frame, out_ready toggling 1,0,0,1,... -> identical byte sequence, out_data stable during stalls, no duplicated or skipped bytes.
- Level done: multiplication_done held high for 20 cycles -> exactly one frame emitted.
- Pending, no bubble: second event (results 0x0102, 0x0304, 0x0506, 0x0708) at byte index 3 of frame 1 -> frame 1 completes, then 01 02 03 04 05 06 07 08 with out_valid continuous and overrun=0.
- Overrun: three events within frame 1, out_ready=0 -> frame 2 pending, frame 3 dropped, overrun=1 and sticky; after drain only frames 1 and 2 appear.
- Reset mid-frame: rst at byte index 4 -> next cycle out_valid=0, busy=0, overrun=0; a fresh event then starts a full frame from byte 0.
